key_move_pulser: RTL and testbench
==================================

// Module: key_move_pulser
// PURPOSE
//  Conditions the four raw DE2 push-buttons (KEY[3:0], active-low) into clean movement strobes
//  for the player-movement stage. Each key is synchronised, debounced, and turned into:
//  - one strobe on press;
//  - auto-repeat strobes while the key is held.
//  Each right/down/up/left strobe is exactly one clock wide. Output drives the movement stage.
//  Ship speed is therefore set here, not by the 50 MHz clock.
// PARAMETERS
//  CNT_W          24          width of every internal counter (all counts below must fit)
//  DEBOUNCE_CYCLES 500_000    cycles a synchronised level must be stable to be accepted (10 ms)
//  REPEAT_DELAY   12_500_000  cycles from press strobe to first repeat strobe (250 ms)
//  REPEAT_PERIOD  833_333     cycles between subsequent repeat strobes (~60 Hz)
// PORTS
//  clock    in   1  50 MHz board clock, all logic on posedge
//  resetn   in   1  asynchronous, active-low reset
//  key_n    in   4  raw KEY[3:0]; 0 = pressed. Map: [3]=left [2]=up [1]=down [0]=right
//  right    out  1  one-cycle movement strobe, +x
//  down     out  1  one-cycle movement strobe, +y
//  up       out  1  one-cycle movement strobe, -y
//  left     out  1  one-cycle movement strobe, -x
//  held     out  4  debounced pressed level per key (1 = held), same bit map as key_n
// BEHAVIOUR
//  Reset (resetn=0, async):
//  - all strobes and held = 0;
//  - synchroniser flops = 1 (released);
//  - all counters = 0;
//  - every key FSM = IDLE.
//  Synchroniser: 2 flops per key; s[i] = ~key_n[i] after 2 edges; no logic on the first flop.
//  Debounce, per key, independent:
//  - The counter increments while s[i] != held[i] and clears when they are equal.
//  - held[i] toggles on the edge where the counter would reach DEBOUNCE_CYCLES.
//  - Glitches shorter than DEBOUNCE_CYCLES produce no change.
//  FSM per key, states IDLE / FIRST / REPEAT:
//  - IDLE -> FIRST on the edge held[i] goes 0->1. The strobe is asserted that same edge, for 1 cycle.
//  - FIRST: the repeat counter counts up from 0. When it hits REPEAT_DELAY-1: strobe for 1 cycle,
//    clear the counter, go to REPEAT.
//  - REPEAT: strobe every REPEAT_PERIOD cycles (counter wraps to 0 at REPEAT_PERIOD-1).
//  - Any state -> IDLE on the edge held[i] goes 1->0. The repeat counter clears.
//  - No strobe is ever generated on release.
//  Latency, key_n stable low: the first strobe is high DEBOUNCE_CYCLES+2 edges after the first
//  edge that samples key_n low. Release is detected with the same latency.
//  Opposing keys:
//  - If left and right strobes would assert in the same cycle, both are suppressed that cycle.
//    Same rule for up/down.
//  - FSMs keep running and are not resynchronised.
//  Non-opposing strobes (e.g. left+up) may assert together and are passed through.
//  Counters saturate-free: REPEAT_* >= 2 and DEBOUNCE_CYCLES >= 1 are required. Widths are CNT_W,
//  and comparisons are unsigned.
//  Reset mid-operation:
//  - Everything returns to reset values immediately.
//  - A key still held when resetn rises is treated as a new press: it re-debounces, then gives a
//    fresh first strobe.
//  Outputs are registered; no combinational path from key_n to any output.
// TESTING  (bench params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5)
//  1. Reset, then key_n[3] low and held 50 cycles -> left=1 on edge 6 after first low sample,
//     again at +20, then +5, +5...; held[3]=1 from edge 6. No other strobe.
//  2. key_n[0] low for 3 cycles then high (glitch) -> right never asserts, held[0] stays 0.
//  3. Press and release key_n[1] after 10 cycles -> exactly one down strobe; held[1] falls
//     6 edges after release; no strobe on release.
//  4. key_n[3] and key_n[0] fall on the same cycle -> left=right=0 at press and at every repeat.
//     Then release key_n[0] -> left repeats resume on schedule.
//  5. key_n[2] held, resetn pulsed low during REPEAT -> all outputs 0 within reset. After resetn=1,
//     up strobes 6 edges later, then the repeat period restarts from REPEAT_DELAY.
//  6. key_n[3] and key_n[2] both held -> left and up strobe together on the same cycles.

Source files
------------

// File: rtl/key_move_pulser.sv
// -----------------------------------------------------------------------------
// key_move_pulser
// Turns the four raw DE2 push-buttons (active-low) into one-clock movement
// strobes. Each key is synchronised, debounced, and then produces one strobe on
// press plus auto-repeat strobes while held. When opposing strobes (left/right
// or up/down) would fire in the same cycle, both are dropped for that cycle.
//
// Ports
//   clock   in   50 MHz board clock, all logic on posedge
//   resetn  in   asynchronous active-low reset
//   key_n   in   [3:0] raw keys, 0 = pressed; [3]=left [2]=up [1]=down [0]=right
//   right   out  one-cycle strobe, +x
//   down    out  one-cycle strobe, +y
//   up      out  one-cycle strobe, -y
//   left    out  one-cycle strobe, -x
//   held    out  [3:0] debounced pressed level per key, same bit map as key_n
// -----------------------------------------------------------------------------
module key_move_pulser #(
   parameter int unsigned CNT_W           = 24,
   parameter int unsigned DEBOUNCE_CYCLES = 500_000,
   parameter int unsigned REPEAT_DELAY    = 12_500_000,
   parameter int unsigned REPEAT_PERIOD   = 833_333
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [3:0] key_n,
   output logic       right,
   output logic       down,
   output logic       up,
   output logic       left,
   output logic [3:0] held
);

   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FIRST,
      ST_REPEAT
   } state_e;

   // Synchroniser holds the raw (active-low) level so reset value 1 = released.
   logic [3:0]       sync1_q, sync2_q;
   logic [3:0]       pressed;

   // deb_q is the accepted level; held_q lags it by one edge so that the held
   // output and the press strobe rise on the same edge.
   logic [3:0]       deb_q, deb_d;
   logic [3:0]       held_q, held_d;
   logic [CNT_W-1:0] db_cnt_q  [4];
   logic [CNT_W-1:0] db_cnt_d  [4];

   state_e           state_q   [4];
   state_e           state_d   [4];
   logic [CNT_W-1:0] rep_cnt_q [4];
   logic [CNT_W-1:0] rep_cnt_d [4];

   // Per-key strobe requests before opposing-key suppression.
   logic [3:0]       pulse;
   // Registered strobes, bit map [3]=left [2]=up [1]=down [0]=right.
   logic [3:0]       strobe_q, strobe_d;

   assign pressed = ~sync2_q;

   // NOTE: every variable written here gets a default first so that no path
   // leaves it unassigned, which would infer a latch.
   always_comb begin
      held_d = deb_q;
      for (int i = 0; i < 4; i++) begin
         // Debounce: count cycles of disagreement, accept the new level once
         // it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
         deb_d[i]    = deb_q[i];
         db_cnt_d[i] = '0;
         if (pressed[i] != deb_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               deb_d[i] = ~deb_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + CNT_ONE;
            end
         end

         // Repeat FSM. The edge detect uses deb_q against held_q, i.e. the
         // edge on which held_q itself changes.
         state_d[i]   = state_q[i];
         rep_cnt_d[i] = rep_cnt_q[i];
         pulse[i]     = 1'b0;
         if (deb_q[i] && !held_q[i]) begin
            state_d[i]   = ST_FIRST;
            rep_cnt_d[i] = '0;
            pulse[i]     = 1'b1;
         end else if (!deb_q[i] && held_q[i]) begin
            state_d[i]   = ST_IDLE;
            rep_cnt_d[i] = '0;
         end else begin
            case (state_q[i])
               ST_IDLE: begin
                  rep_cnt_d[i] = '0;
               end
               ST_FIRST: begin
                  if (rep_cnt_q[i] == DLY_LAST) begin
                     pulse[i]     = 1'b1;
                     rep_cnt_d[i] = '0;
                     state_d[i]   = ST_REPEAT;
                  end else begin
                     rep_cnt_d[i] = rep_cnt_q[i] + CNT_ONE;
                  end
               end
               ST_REPEAT: begin
                  if (rep_cnt_q[i] == PER_LAST) begin
                     pulse[i]     = 1'b1;
                     rep_cnt_d[i] = '0;
                  end else begin
                     rep_cnt_d[i] = rep_cnt_q[i] + CNT_ONE;
                  end
               end
               default: begin
                  state_d[i]   = ST_IDLE;
                  rep_cnt_d[i] = '0;
               end
            endcase
         end
      end

      // Opposing pairs cancel; the FSMs themselves are left untouched.
      strobe_d[0] = pulse[0] & ~pulse[3];
      strobe_d[3] = pulse[3] & ~pulse[0];
      strobe_d[1] = pulse[1] & ~pulse[2];
      strobe_d[2] = pulse[2] & ~pulse[1];
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync1_q  <= 4'hF;
         sync2_q  <= 4'hF;
         deb_q    <= '0;
         held_q   <= '0;
         strobe_q <= '0;
         for (int i = 0; i < 4; i++) begin
            db_cnt_q[i]  <= '0;
            rep_cnt_q[i] <= '0;
            state_q[i]   <= ST_IDLE;
         end
      end else begin
         sync1_q  <= key_n;
         sync2_q  <= sync1_q;
         deb_q    <= deb_d;
         held_q   <= held_d;
         strobe_q <= strobe_d;
         for (int i = 0; i < 4; i++) begin
            db_cnt_q[i]  <= db_cnt_d[i];
            rep_cnt_q[i] <= rep_cnt_d[i];
            state_q[i]   <= state_d[i];
         end
      end
   end

   assign right = strobe_q[0];
   assign down  = strobe_q[1];
   assign up    = strobe_q[2];
   assign left  = strobe_q[3];
   assign held  = held_q;

endmodule

// File: tb/tb_key_move_pulser.sv
// -----------------------------------------------------------------------------
// tb_key_move_pulser
// Directed scenarios followed by random key activity, every cycle compared
// against a reference model built from the timing rules: a key is accepted
// once its last DEBOUNCE samples (seen through a 2-flop synchroniser) all
// disagree with the accepted level, held follows one edge later, and strobes
// fall at press, press+DELAY, press+DELAY+k*PERIOD while held.
// -----------------------------------------------------------------------------
module tb_key_move_pulser;

   localparam int DEB = 4;
   localparam int DLY = 20;
   localparam int PER = 5;

   logic       clock = 1'b0;
   logic       resetn;
   logic [3:0] key_n;
   logic       right, down, up, left;
   logic [3:0] held;

   key_move_pulser #(
      .CNT_W          (24),
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_DELAY   (DLY),
      .REPEAT_PERIOD  (PER)
   ) dut (
      .clock (clock),
      .resetn(resetn),
      .key_n (key_n),
      .right (right),
      .down  (down),
      .up    (up),
      .left  (left),
      .held  (held)
   );

   always #5 clock = ~clock;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state: pressed samples since reset, indexed by edge.
   logic [3:0] hist [$];
   logic [3:0] acc_m;
   logic [3:0] held_m;
   int         press_edge [4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic samp(input int k, input int i);
      if (k < 0) return 1'b0;
      return hist[k][i];
   endfunction

   task automatic model_reset();
      hist.delete();
      acc_m  = '0;
      held_m = '0;
      for (int i = 0; i < 4; i++) press_edge[i] = 0;
   endtask

   // One clock edge: advance the model, then compare all outputs.
   task automatic tick(input string tag);
      logic [3:0] raw;
      logic [3:0] held_new;
      logic [7:0] exp_out;
      logic       all_diff;
      int         n;
      int         d;
      @(posedge clock);
      hist.push_back(~key_n);
      n        = hist.size() - 1;
      held_new = acc_m;
      for (int i = 0; i < 4; i++) begin
         all_diff = 1'b1;
         for (int k = n - DEB - 1; k <= n - 2; k++)
            if (samp(k, i) == acc_m[i]) all_diff = 1'b0;
         if (all_diff) acc_m[i] = ~acc_m[i];
         raw[i] = 1'b0;
         if (held_new[i] && !held_m[i]) begin
            press_edge[i] = n;
            raw[i]        = 1'b1;
         end else if (held_new[i]) begin
            d      = n - press_edge[i];
            raw[i] = (d >= DLY) && ((d - DLY) % PER == 0);
         end
      end
      held_m  = held_new;
      exp_out = {raw[3] & ~raw[0], raw[2] & ~raw[1], raw[1] & ~raw[2], raw[0] & ~raw[3], held_new};
      #1;
      check(tag, {24'd0, left, up, down, right, held}, {24'd0, exp_out});
   endtask

   // Asynchronous reset pulse issued between edges; outputs must clear at once.
   task automatic do_reset(input string tag);
      resetn = 1'b0;
      #1;
      check(tag, {27'd0, left, up, down, right, held == 4'h0}, 32'h1);
      repeat (2) @(posedge clock);
      #1;
      check(tag, {24'd0, left, up, down, right, held}, 32'h0);
      resetn = 1'b1;
      model_reset();
   endtask

   initial begin : stim
      int cnt;
      int cnt2;
      int first;
      int last_held;
      int hold_len;

      // Power-up reset.
      key_n  = 4'hF;
      resetn = 1'b0;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      check("reset_state", {24'd0, left, up, down, right, held}, 32'h0);
      resetn = 1'b1;

      // 1: left held 50 cycles -> strobes at 6, 26, 31, 36, 41, 46.
      key_n = 4'b0111;
      cnt   = 0;
      first = -1;
      for (int j = 0; j < 50; j++) begin
         tick("t1_cycle");
         if (left) begin
            cnt++;
            if (first < 0) first = j;
         end
      end
      check("t1_first_left", first, 6);
      check("t1_left_count", cnt, 6);
      key_n = 4'hF;
      for (int j = 0; j < 10; j++) tick("t1_release");

      // 2: 3-cycle glitch on right -> nothing.
      key_n = 4'b1110;
      cnt   = 0;
      cnt2  = 0;
      for (int j = 0; j < 13; j++) begin
         if (j == 3) key_n = 4'hF;
         tick("t2_cycle");
         if (right) cnt++;
         if (held[0]) cnt2++;
      end
      check("t2_right_count", cnt, 0);
      check("t2_held_count", cnt2, 0);

      // 3: down pressed 10 cycles -> one strobe, held falls at edge 16.
      key_n     = 4'b1101;
      cnt       = 0;
      last_held = -1;
      for (int j = 0; j < 30; j++) begin
         if (j == 10) key_n = 4'hF;
         tick("t3_cycle");
         if (down) cnt++;
         if (held[1]) last_held = j;
      end
      check("t3_down_count", cnt, 1);
      check("t3_held_fall", last_held + 1, 16);

      // 4: left+right together -> all suppressed; release right -> left resumes.
      key_n = 4'b0110;
      cnt   = 0;
      for (int j = 0; j < 40; j++) begin
         tick("t4_both");
         if (left || right) cnt++;
      end
      check("t4_suppressed", cnt, 0);
      key_n = 4'b0111;
      cnt   = 0;
      first = -1;
      for (int j = 40; j < 60; j++) begin
         tick("t4_left_only");
         if (left) begin
            cnt++;
            if (first < 0) first = j;
         end
      end
      check("t4_first_resume", first, 46);
      check("t4_left_count", cnt, 3);
      key_n = 4'hF;
      for (int j = 0; j < 10; j++) tick("t4_release");

      // 5: up held, reset during REPEAT -> fresh press timing afterwards.
      key_n = 4'b1011;
      for (int j = 0; j < 35; j++) tick("t5_pre");
      #2;
      do_reset("t5_reset");
      cnt   = 0;
      first = -1;
      for (int j = 0; j < 30; j++) begin
         tick("t5_post");
         if (up) begin
            cnt++;
            if (first < 0) first = j;
         end
      end
      check("t5_first_up", first, 6);
      check("t5_up_count", cnt, 2);
      key_n = 4'hF;
      for (int j = 0; j < 10; j++) tick("t5_release");

      // 6: left+up held -> coincident strobes at 6, 26, 31, 36.
      key_n = 4'b0011;
      cnt   = 0;
      cnt2  = 0;
      for (int j = 0; j < 40; j++) begin
         tick("t6_cycle");
         if (left && up) cnt++;
         if (left ^ up) cnt2++;
      end
      check("t6_together", cnt, 4);
      check("t6_apart", cnt2, 0);
      key_n = 4'hF;
      for (int j = 0; j < 10; j++) tick("t6_release");

      // Random key activity with occasional resets.
      for (int s = 0; s < 150; s++) begin
         key_n    = 4'($urandom);
         hold_len = int'($urandom_range(1, 30));
         for (int j = 0; j < hold_len; j++) tick("rand_cycle");
         if ($urandom_range(0, 39) == 0) begin
            #2;
            do_reset("rand_reset");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
